alu_master_seq: RTL and testbench
=================================

Name: alu_master_seq

Overview:
- Parametrised successor to the single-instruction register/ALU master.
- Accepts 16-bit register-register instructions over a valid/ready handshake and executes them through a multi-cycle FSM (READ, EXEC, WB) against a 16-entry register file of width DATA_W.
- Maintains N/Z/C/V flags and drives a selectable display bus.
- An optional step prescaler slows execution so progress is visible on board.

Parameters:
- DATA_W, 16, register/ALU/display width; must be ≥8.
- TICK_DIV, 1, boardclk cycles per FSM step after accept; 1 means every cycle.

Ports:
- boardclk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- ins  in  16  instruction: op[15:12], Rx[11:8], Ry[7:4], Rz[3:0].
- ins_valid  in  1  instruction present.
- ins_ready  out  1  high only in IDLE; accept when ins_valid&ins_ready at a rising edge.
- disp_sel  in  4  register index shown when disp_mode=1.
- disp_mode  in  1  0 = last result, 1 = register[disp_sel] (combinational read).
- disp  out  DATA_W  display value.
- flags  out  4  {N,Z,C,V}.
- done  out  1  one-cycle pulse after writeback.
- busy  out  1  equals ~ins_ready.

Behaviour:
- Reset state:
  - register i = i (zero-extended).
  - last_result=0, flags=0, done=0.
  - state IDLE, ins_ready=1, prescaler count=0.
- Reset mid-operation aborts immediately: no writeback, no done pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; tick=1 when count==TICK_DIV-1.
  - Counts continuously, but is cleared to 0 on accept.
  - With TICK_DIV=1, tick is always 1.
- FSM sequence IDLE -> READ -> EXEC -> WB -> IDLE:
  - IDLE: accept latches ins and moves to READ; acceptance is not tick-gated.
  - READ: latches operands A=R[Rx], B=R[Ry]; advances on tick.
  - EXEC: latches ALU result and flag candidates; advances on tick.
  - WB: on tick, writes R[Rz] (if the op writes), updates last_result and flags, returns to IDLE; done=1 in the following cycle.
- Latency at TICK_DIV=1: accept at edge E0, done high during the cycle after E3, ins_ready high again after E3. Peak throughput is 1 instruction per 4 cycles.
- While busy, ins_valid and ins are ignored. A source holding valid is accepted on the first edge with ins_ready=1.
- Opcodes (Rz is the destination):
  - 0000 ADD: Rz=A+B; C=carry out; V=signed overflow.
  - 0001 SUB: Rz=A-B; C=borrow (A<B unsigned); V=signed overflow.
  - 0010 AND, 0011 OR, 0100 XOR: bitwise.
  - 0101 NOT: Rz=~A.
  - 0110 SHL: Rz=A<<(B mod DATA_W), logical.
  - 0111 SHR: Rz=A>>(B mod DATA_W), logical.
  - 1000 LDI: Rz=sign-extend({Rx,Ry}) to DATA_W.
  - 1001 MOV: Rz=A.
  - 1010 CMP: computes SUB and updates flags and last_result; no register write.
  - 1011-1111: NOP; no write, flags and last_result unchanged, done still pulses.
- Flag rules:
  - Z=(result==0); N=result[DATA_W-1].
  - C=V=0 for all ops except ADD/SUB/CMP.
- All arithmetic is modulo 2^DATA_W.
- Rz may equal Rx/Ry: operands are taken at READ, so the new value is visible only to later instructions.

Test Plan (DATA_W=16, TICK_DIV=1 unless stated):
1. Reset, disp_mode=1, disp_sel=5 -> disp=0x0005, ins_ready=1, flags=0000.
2. ins=0111_0001_1111_0001 (SHR R1 by R15) accepted at E0 -> R1=0x0000, disp(mode 0)=0x0000, Z=1, done high only in the cycle after E3.
3. LDI 1000_1111_1111_0010 -> R2=0xFFFF, N=1. Then ADD 0000_0010_0001_0011 (R1=1 restored by reset) -> R3=0x0000, Z=1, C=1, V=0.
4. SHL 0110_0001_1111_0101 -> R5=0x8000, N=1. Then SUB 0001_0101_0001_0110 -> R6=0x7FFF, V=1, C=0, N=0. Then opcode 1111 -> registers, flags and disp unchanged; done pulses.
5. TICK_DIV=4, ins_valid held high with two back-to-back instructions -> first done 12 cycles after accept; second accepted on the first edge with ins_ready=1; ins ignored while busy.
6. Assert rst=0 while in EXEC of ADD into R7 -> immediate return to IDLE, R7=0x0007, no done pulse, flags=0000.

Source files
------------

// File: rtl/alu_master_seq.sv
// alu_master_seq: multi-cycle register/ALU master.
// Instructions arrive over a valid/ready handshake and are executed through
// READ -> EXEC -> WB against a 16-entry register file, updating N/Z/C/V flags.
// An optional step prescaler stretches each FSM step so execution is visible on a board.
module alu_master_seq #(
    parameter int DATA_W   = 16,
    parameter int TICK_DIV = 1
) (
    input  logic              boardclk,
    input  logic              rst,
    input  logic [15:0]       ins,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [3:0]        disp_sel,
    input  logic              disp_mode,
    output logic [DATA_W-1:0] disp,
    output logic [3:0]        flags,
    output logic              done,
    output logic              busy
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic              tick;
    logic              accept;

    logic [15:0]       ins_q;
    logic [3:0]        op;
    logic [3:0]        rx;
    logic [3:0]        ry;
    logic [3:0]        rz;
    logic              writes_reg;
    logic              updates_flags;

    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] res_q;
    logic [3:0]        flags_cand;
    logic [DATA_W-1:0] last_result;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] shamt;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic [3:0]        flags_c;

    assign op     = ins_q[15:12];
    assign rx     = ins_q[11:8];
    assign ry     = ins_q[7:4];
    assign rz     = ins_q[3:0];

    // Opcodes 0..9 write Rz; CMP (0xA) only touches flags/last_result; 0xB..0xF are NOPs
    assign writes_reg    = (op <= 4'h9);
    assign updates_flags = (op <= 4'hA);

    assign ins_ready = (state == IDLE);
    assign busy      = ~ins_ready;
    assign accept    = ins_valid & ins_ready;
    assign tick      = (count == CNT_MAX);
    assign disp      = disp_mode ? regs[disp_sel] : last_result;

    // Step prescaler: free-running 0..TICK_DIV-1, restarted on accept so every instruction sees equal step lengths
    always_ff @(posedge boardclk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
        end else if (count == CNT_MAX) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge boardclk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: acceptance is immediate, every later step waits for a prescaler tick
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ins_valid) state_next = READ;
            READ:    if (tick) state_next = EXEC;
            EXEC:    if (tick) state_next = WB;
            WB:      if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ALU: combinational on the operands captured in READ
    always_comb begin
        sum     = {1'b0, opa} + {1'b0, opb};
        diff    = {1'b0, opa} - {1'b0, opb};
        shamt   = DATA_W'(opb % DATA_W);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            4'h0: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (opa[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != opa[DATA_W-1]);
            end
            4'h1, 4'hA: begin
                alu_res = diff[DATA_W-1:0];
                alu_c   = diff[DATA_W];
                alu_v   = (opa[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != opa[DATA_W-1]);
            end
            4'h2:    alu_res = opa & opb;
            4'h3:    alu_res = opa | opb;
            4'h4:    alu_res = opa ^ opb;
            4'h5:    alu_res = ~opa;
            4'h6:    alu_res = opa << shamt;
            4'h7:    alu_res = opa >> shamt;
            4'h8:    alu_res = DATA_W'($signed(ins_q[11:4]));
            4'h9:    alu_res = opa;
            default: alu_res = '0;
        endcase
        flags_c = {alu_res[DATA_W-1], (alu_res == '0), alu_c, alu_v};
    end

    // Datapath pipeline: instruction on accept, operands in READ, result and flag candidates in EXEC
    always_ff @(posedge boardclk or negedge rst) begin
        if (!rst) begin
            ins_q      <= '0;
            opa        <= '0;
            opb        <= '0;
            res_q      <= '0;
            flags_cand <= '0;
        end else begin
            if (accept) begin
                ins_q <= ins;
            end
            if (state == READ && tick) begin
                opa <= regs[rx];
                opb <= regs[ry];
            end
            if (state == EXEC && tick) begin
                res_q      <= alu_res;
                flags_cand <= flags_c;
            end
        end
    end

    // Register file: reset to its own index, written only at the end of WB
    always_ff @(posedge boardclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (state == WB && tick && writes_reg) begin
            regs[rz] <= res_q;
        end
    end

    // Architectural results and the completion pulse, committed together at the end of WB
    always_ff @(posedge boardclk or negedge rst) begin
        if (!rst) begin
            last_result <= '0;
            flags       <= '0;
            done        <= 1'b0;
        end else begin
            done <= (state == WB) && tick;
            if (state == WB && tick && updates_flags) begin
                last_result <= res_q;
                flags       <= flags_cand;
            end
        end
    end

endmodule

// File: tb/tb_alu_master_seq.sv
// tb_alu_master_seq: scoreboard bench for alu_master_seq.
// One instance runs at TICK_DIV=1, a second at TICK_DIV=4 for prescaled back-to-back traffic.
module tb_alu_master_seq;

    logic        boardclk = 1'b0;
    logic        rst;
    logic [15:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [3:0]  disp_sel;
    logic        disp_mode;
    logic [15:0] disp;
    logic [3:0]  flags;
    logic        done;
    logic        busy;

    logic [15:0] ins4;
    logic        ins_valid4;
    logic        ins_ready4;
    logic [3:0]  disp_sel4;
    logic        disp_mode4;
    logic [15:0] disp4;
    logic [3:0]  flags4;
    logic        done4;
    logic        busy4;

    typedef struct {
        logic [15:0] last;
        logic [3:0]  flags;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb4[$];
    exp_t        mon_e0;
    exp_t        mon_e4;

    logic [15:0] m_regs [2][16];
    logic [15:0] m_last [2];
    logic [3:0]  m_flags [2];

    int checks   = 0;
    int failures = 0;

    always #5 boardclk = ~boardclk;

    alu_master_seq #(.DATA_W(16), .TICK_DIV(1)) dut (
        .boardclk (boardclk),
        .rst      (rst),
        .ins      (ins),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .disp_sel (disp_sel),
        .disp_mode(disp_mode),
        .disp     (disp),
        .flags    (flags),
        .done     (done),
        .busy     (busy)
    );

    alu_master_seq #(.DATA_W(16), .TICK_DIV(4)) dut4 (
        .boardclk (boardclk),
        .rst      (rst),
        .ins      (ins4),
        .ins_valid(ins_valid4),
        .ins_ready(ins_ready4),
        .disp_sel (disp_sel4),
        .disp_mode(disp_mode4),
        .disp     (disp4),
        .flags    (flags4),
        .done     (done4),
        .busy     (busy4)
    );

    // Reference model state returns to the power-on register contents
    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 16; r++) begin
                m_regs[k][r] = 16'(r);
            end
            m_last[k]  = 16'h0000;
            m_flags[k] = 4'b0000;
        end
    endfunction

    // Reference ALU for 16-bit data; applies the instruction to model k and returns expected last/flags
    function automatic void model(input int k, input logic [15:0] i, output exp_t e);
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        wr;
        logic        upd;
        int          sa;
        int          sb;
        op  = i[15:12];
        a   = m_regs[k][i[11:8]];
        b   = m_regs[k][i[7:4]];
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        res = 16'h0000;
        c   = 1'b0;
        v   = 1'b0;
        wr  = 1'b1;
        upd = 1'b1;
        case (op)
            4'h0: begin
                res = a + b;
                c   = (int'(a) + int'(b)) > 65535;
                v   = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            4'h1, 4'hA: begin
                res = a - b;
                c   = (a < b);
                v   = ((sa - sb) > 32767) || ((sa - sb) < -32768);
                wr  = (op == 4'h1);
            end
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = ~a;
            4'h6: res = a << b[3:0];
            4'h7: res = a >> b[3:0];
            4'h8: res = {{8{i[11]}}, i[11:4]};
            4'h9: res = a;
            default: begin
                wr  = 1'b0;
                upd = 1'b0;
            end
        endcase
        if (upd) begin
            m_last[k]  = res;
            m_flags[k] = {res[15], (res == 16'h0000), c, v};
        end
        if (wr) begin
            m_regs[k][i[3:0]] = res;
        end
        e.last  = m_last[k];
        e.flags = m_flags[k];
    endfunction

    // Scoreboard monitor: every done pulse retires the oldest expectation of its instance
    always @(negedge boardclk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            checks++;
            if (sb0.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb0_unexpected_done: done=1 with no instruction pending");
            end else begin
                mon_e0 = sb0.pop_front();
                checks++;
                if (flags !== mon_e0.flags) begin
                    failures++;
                    $display("[TB] FAIL sb0_flags: got %b expected %b", flags, mon_e0.flags);
                end
                if (disp_mode === 1'b0) begin
                    checks++;
                    if (disp !== mon_e0.last) begin
                        failures++;
                        $display("[TB] FAIL sb0_last_result: got %h expected %h", disp, mon_e0.last);
                    end
                end
            end
        end
        if (rst === 1'b1 && done4 === 1'b1) begin
            checks++;
            if (sb4.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb4_unexpected_done: done=1 with no instruction pending");
            end else begin
                mon_e4 = sb4.pop_front();
                checks++;
                if (flags4 !== mon_e4.flags) begin
                    failures++;
                    $display("[TB] FAIL sb4_flags: got %b expected %b", flags4, mon_e4.flags);
                end
                if (disp_mode4 === 1'b0) begin
                    checks++;
                    if (disp4 !== mon_e4.last) begin
                        failures++;
                        $display("[TB] FAIL sb4_last_result: got %h expected %h", disp4, mon_e4.last);
                    end
                end
            end
        end
    end

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        @(negedge boardclk);
        rst        = 1'b0;
        ins_valid  = 1'b0;
        ins_valid4 = 1'b0;
        @(negedge boardclk);
        @(negedge boardclk);
        rst = 1'b1;
        model_reset();
    endtask

    // Drives one instruction into the TICK_DIV=1 instance and follows it to completion
    task automatic issue_ins(input logic [15:0] i, input string tag);
        exp_t e;
        int   edges;
        model(0, i, e);
        sb0.push_back(e);
        @(negedge boardclk);
        checks++;
        if (ins_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_ready_before: got %b expected 1", tag, ins_ready);
        end
        ins       = i;
        ins_valid = 1'b1;
        @(posedge boardclk);
        #1;
        ins_valid = 1'b0;
        ins       = 16'h8ABA;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_busy_after_accept: got %b expected 1", tag, busy);
        end
        edges = 0;
        while (edges < 20) begin
            @(posedge boardclk);
            #1;
            edges++;
            if (done === 1'b1) break;
        end
        checks++;
        if (edges != 3) begin
            failures++;
            $display("[TB] FAIL %s_latency: got %0d edges expected 3", tag, edges);
        end
        checks++;
        if (ins_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_ready_after: got %b expected 1", tag, ins_ready);
        end
        @(negedge boardclk);
        #1;
        disp_mode = 1'b1;
        disp_sel  = i[3:0];
        #1;
        checks++;
        if (disp !== m_regs[0][i[3:0]]) begin
            failures++;
            $display("[TB] FAIL %s_dest_reg: R%0d got %h expected %h", tag, i[3:0], disp, m_regs[0][i[3:0]]);
        end
        disp_mode = 1'b0;
        @(posedge boardclk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_done_width: got %b expected 0", tag, done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        disp_mode = 1'b1;
        disp_sel  = 4'd5;
        #1;
        checks++;
        if (disp !== 16'h0005) begin
            failures++;
            $display("[TB] FAIL reset_disp: got %h expected 0005", disp);
        end
        checks++;
        if (ins_ready !== 1'b1 || busy !== 1'b0 || ins_ready4 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got ready=%b busy=%b ready4=%b expected 1 0 1", ins_ready, busy, ins_ready4);
        end
        checks++;
        if (flags !== 4'b0000 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got flags=%b done=%b expected 0000 0", flags, done);
        end
        for (int r = 0; r < 16; r++) begin
            disp_sel = 4'(r);
            #1;
            checks++;
            if (disp !== 16'(r)) begin
                failures++;
                $display("[TB] FAIL reset_reg: R%0d got %h expected %h", r, disp, 16'(r));
            end
        end
        disp_mode = 1'b0;
        #1;
        checks++;
        if (disp !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_last_result: got %h expected 0000", disp);
        end
    endtask

    task automatic test_shr();
        issue_ins(16'h71F1, "shr");
        checks++;
        if (flags !== 4'b0100 || disp !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL shr_result: got flags=%b disp=%h expected 0100 0000", flags, disp);
        end
    endtask

    task automatic test_ldi_add();
        do_reset();
        issue_ins(16'h8FF2, "ldi");
        checks++;
        if (flags !== 4'b1000 || disp !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL ldi_result: got flags=%b disp=%h expected 1000 ffff", flags, disp);
        end
        issue_ins(16'h0213, "add");
        checks++;
        if (flags !== 4'b0110 || disp !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL add_result: got flags=%b disp=%h expected 0110 0000", flags, disp);
        end
    endtask

    task automatic test_shl_sub_nop();
        issue_ins(16'h61F5, "shl");
        checks++;
        if (flags !== 4'b1000 || disp !== 16'h8000) begin
            failures++;
            $display("[TB] FAIL shl_result: got flags=%b disp=%h expected 1000 8000", flags, disp);
        end
        issue_ins(16'h1516, "sub");
        checks++;
        if (flags !== 4'b0001 || disp !== 16'h7FFF) begin
            failures++;
            $display("[TB] FAIL sub_result: got flags=%b disp=%h expected 0001 7fff", flags, disp);
        end
        issue_ins(16'hF000, "nop");
        checks++;
        if (flags !== 4'b0001 || disp !== 16'h7FFF) begin
            failures++;
            $display("[TB] FAIL nop_unchanged: got flags=%b disp=%h expected 0001 7fff", flags, disp);
        end
        disp_mode = 1'b1;
        for (int r = 0; r < 16; r++) begin
            disp_sel = 4'(r);
            #1;
            checks++;
            if (disp !== m_regs[0][r]) begin
                failures++;
                $display("[TB] FAIL nop_regs: R%0d got %h expected %h", r, disp, m_regs[0][r]);
            end
        end
        disp_mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   edges;
        model(1, 16'h8128, e);
        sb4.push_back(e);
        model(1, 16'h0819, e);
        sb4.push_back(e);
        @(negedge boardclk);
        checks++;
        if (ins_ready4 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ready_before: got %b expected 1", ins_ready4);
        end
        ins4       = 16'h8128;
        ins_valid4 = 1'b1;
        @(posedge boardclk);
        #1;
        ins4 = 16'h8ABA;
        checks++;
        if (busy4 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_busy_first: got %b expected 1", busy4);
        end
        edges = 0;
        while (edges < 40) begin
            @(posedge boardclk);
            #1;
            edges++;
            if (edges == 8) ins4 = 16'h0819;
            if (done4 === 1'b1) break;
        end
        checks++;
        if (edges != 12) begin
            failures++;
            $display("[TB] FAIL b2b_first_latency: got %0d edges expected 12", edges);
        end
        checks++;
        if (ins_ready4 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ready_between: got %b expected 1", ins_ready4);
        end
        @(posedge boardclk);
        #1;
        checks++;
        if (busy4 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_second_accept: got busy=%b expected 1", busy4);
        end
        ins_valid4 = 1'b0;
        edges = 0;
        while (edges < 40) begin
            @(posedge boardclk);
            #1;
            edges++;
            if (done4 === 1'b1) break;
        end
        checks++;
        if (edges != 12) begin
            failures++;
            $display("[TB] FAIL b2b_second_latency: got %0d edges expected 12", edges);
        end
        @(negedge boardclk);
        #1;
        disp_mode4 = 1'b1;
        disp_sel4  = 4'd8;
        #1;
        checks++;
        if (disp4 !== 16'h0012) begin
            failures++;
            $display("[TB] FAIL b2b_r8: got %h expected 0012", disp4);
        end
        disp_sel4 = 4'd9;
        #1;
        checks++;
        if (disp4 !== 16'h0013) begin
            failures++;
            $display("[TB] FAIL b2b_r9: got %h expected 0013", disp4);
        end
        disp_sel4 = 4'd10;
        #1;
        checks++;
        if (disp4 !== 16'h000A) begin
            failures++;
            $display("[TB] FAIL b2b_ignored_ins: R10 got %h expected 000a", disp4);
        end
        disp_mode4 = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic seen;
        @(negedge boardclk);
        checks++;
        if (ins_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_ready_before: got %b expected 1", ins_ready);
        end
        ins       = 16'h0127;
        ins_valid = 1'b1;
        @(posedge boardclk);
        #1;
        ins_valid = 1'b0;
        @(posedge boardclk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_busy_exec: got %b expected 1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ins_ready !== 1'b1 || done !== 1'b0 || flags !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL abort_immediate: got ready=%b done=%b flags=%b expected 1 0 0000", ins_ready, done, flags);
        end
        @(negedge boardclk);
        @(negedge boardclk);
        rst = 1'b1;
        model_reset();
        seen = 1'b0;
        repeat (8) begin
            @(posedge boardclk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_done: got done pulse=%b expected 0", seen);
        end
        disp_mode = 1'b1;
        disp_sel  = 4'd7;
        #1;
        checks++;
        if (disp !== 16'h0007) begin
            failures++;
            $display("[TB] FAIL abort_r7: got %h expected 0007", disp);
        end
        disp_mode = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        ins        = 16'h0000;
        ins_valid  = 1'b0;
        disp_sel   = 4'd0;
        disp_mode  = 1'b0;
        ins4       = 16'h0000;
        ins_valid4 = 1'b0;
        disp_sel4  = 4'd0;
        disp_mode4 = 1'b0;
        model_reset();

        test_reset();
        test_shr();
        test_ldi_add();
        test_shl_sub_nop();
        test_back_to_back();
        test_reset_abort();

        checks++;
        if (sb0.size() != 0 || sb4.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", sb0.size(), sb4.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
